// File: rtl/dpu_ibuf.sv
// Decode-stage instruction/PC queue between the PFU and execute, with
// flush/stall handling and JAL redirect detection at the queue head.
module dpu_ibuf #(
  parameter  int INST_W = 32,
  parameter  int PC_W   = 32,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pfu2dpu_valid_i,
  input  logic [INST_W-1:0] pfu2dpu_inst_i,
  input  logic [PC_W-1:0]   pfu2dpu_pc_i,
  output logic              dpu2pfu_ready_o,
  input  logic              ctrl2dpu_flush_i,
  input  logic              ctrl2dpu_stall_i,
  output logic              dpu2ex_valid_o,
  output logic [INST_W-1:0] dpu2ex_inst_o,
  output logic [PC_W-1:0]   dpu2ex_pc_o,
  input  logic              ex2dpu_ready_i,
  output logic [PC_W-1:0]   dpu2ctrl_branch_pc_o,
  output logic              dpu2ctrl_valid_o,
  output logic [CNT_W-1:0]  dpu2ctrl_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [PC_W-1:0]   branch_pc_q;
  logic              redir_vld_p1;

  logic empty, full, enq, deq, jal_take;
  logic [INST_W-1:0] head_inst;
  logic [PC_W-1:0]   head_pc;

  // J-type immediate from inst[31:12], sign-extended to PC_W.
  function automatic logic signed [PC_W-1:0] j_imm(input logic [19:0] hi);
    logic signed [20:0] imm;
    imm = {hi[19], hi[7:0], hi[8], hi[18:9], 1'b0};
    return {{(PC_W-21){imm[20]}}, imm};
  endfunction

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign head_inst = inst_mem[rptr_q[AW-1:0]];
  assign head_pc   = pc_mem[rptr_q[AW-1:0]];

  assign dpu2pfu_ready_o = !full && !ctrl2dpu_flush_i;
  assign dpu2ex_valid_o  = !empty && !ctrl2dpu_stall_i;
  assign dpu2ex_inst_o   = head_inst;
  assign dpu2ex_pc_o     = head_pc;

  assign enq      = pfu2dpu_valid_i && dpu2pfu_ready_o;
  assign deq      = dpu2ex_valid_o && ex2dpu_ready_i;
  assign jal_take = deq && (head_inst[6:0] == OPC_JAL);

  // Queue state and redirect register; flush outranks JAL, JAL outranks enqueue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      branch_pc_q  <= '0;
      redir_vld_p1 <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      redir_vld_p1 <= 1'b0;
      if (ctrl2dpu_flush_i) begin
        wptr_q  <= rptr_q;
        count_q <= '0;
      end else if (jal_take) begin
        rptr_q       <= rptr_q + PTR_ONE;
        wptr_q       <= rptr_q + PTR_ONE;
        count_q      <= '0;
        redir_vld_p1 <= 1'b1;
        branch_pc_q  <= PC_W'($signed(head_pc) + j_imm(head_inst[31:12]));
      end else begin
        if (enq) begin
          inst_mem[wptr_q[AW-1:0]] <= pfu2dpu_inst_i;
          pc_mem[wptr_q[AW-1:0]]   <= pfu2dpu_pc_i;
          wptr_q                   <= wptr_q + PTR_ONE;
        end
        if (deq) begin
          rptr_q <= rptr_q + PTR_ONE;
        end
        count_q <= count_q + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  assign dpu2ctrl_branch_pc_o = branch_pc_q;
  assign dpu2ctrl_valid_o     = redir_vld_p1;
  assign dpu2ctrl_count_o     = count_q;

endmodule
